// File: rtl/btu_pkg.sv
// btu_pkg: shared FSM encoding, default sizes and clog2 helper for the block transfer unit.
package btu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;
  localparam int DEF_WSIZE = 32;
  localparam int DEF_WPB = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/block_xfer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above the pointer, with wrap.
module rr_arbiter
  import btu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);
  logic [IW-1:0] w_idx;
  // Scanning from the farthest offset down lets the closest request to the pointer win.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = i_rr_ptr + IW'(k);
      if (i_req[w_idx]) begin
        o_gnt = NREQ'(1) << w_idx;
        o_idx = w_idx;
      end
    end
  end
endmodule

// File: rtl/block_xfer_arbiter.sv
// block_xfer_arbiter: round-robin owner of a word channel that moves whole WPB-word blocks.
// Optional stall timeout that aborts a burst is enabled with macro BXA_TIMEOUT_EN.
module block_xfer_arbiter
  import btu_pkg::*;
#(
  parameter int WSIZE = DEF_WSIZE,
  parameter int NREQ = 4,
  parameter int WPB = DEF_WPB,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WSIZE-1:0]    req_word,
  input  logic [NREQ-1:0]          req_word_valid,
  output logic [NREQ-1:0]          req_word_pop,
  output logic [NREQ-1:0]          grant,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic [WSIZE-1:0]         word_out,
  output logic                     word_out_valid,
  input  logic                     word_out_ready,
  output logic                     block_done,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(WPB);
  state_t r_state, w_next;
  logic [NREQ-1:0] r_grant, w_arb_gnt;
  logic [IW-1:0] r_grant_id, r_rr_ptr, w_arb_idx;
  logic [CW-1:0] r_cnt;
  logic w_beat, w_last, w_timeout;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req(req), .i_rr_ptr(r_rr_ptr), .o_gnt(w_arb_gnt), .o_idx(w_arb_idx)
  );

  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;

  // A request withdrawn before arbitration leaves no owner, so fall back to IDLE.
  always_comb begin
    word_out_valid = r_state == XFER && req_word_valid[r_grant_id];
    w_beat = word_out_valid && word_out_ready;
    w_last = r_cnt == CW'(WPB - 1);
    word_out = word_out_valid ? req_word[r_grant_id*WSIZE +: WSIZE] : '0;
    req_word_pop = w_beat ? r_grant : '0;
    block_done = r_state == DONE;
    busy = r_state != IDLE;
    w_next = r_state == IDLE ? (|req ? ARB : IDLE) :
             r_state == ARB  ? (|w_arb_gnt ? XFER : IDLE) :
             r_state == XFER ? (w_timeout ? IDLE : (w_beat && w_last) ? DONE : XFER) :
             IDLE;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_grant <= '0;
      r_grant_id <= '0;
      r_rr_ptr <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == ARB) begin
        r_grant <= w_arb_gnt;
        r_grant_id <= w_arb_idx;
      end
      if (w_beat) r_cnt <= r_cnt + 1'b1;
      if (r_state == DONE || w_timeout) begin
        r_grant <= '0;
        r_grant_id <= '0;
        r_rr_ptr <= r_grant_id + 1'b1;
        r_cnt <= '0;
      end
    end

`ifdef BXA_TIMEOUT_EN
  localparam int SW = clog2(TIMEOUT + 1);
  logic [SW-1:0] r_stall;
  assign w_timeout = r_state == XFER && !w_beat && r_stall == SW'(TIMEOUT - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) r_stall <= '0;
    else r_stall <= (r_state == XFER && !w_beat && !w_timeout) ? r_stall + 1'b1 : '0;
`else
  assign w_timeout = 1'b0;
`endif

  assign grant = r_grant;
  assign grant_id = r_grant_id;
  assign timeout_err = w_timeout;
endmodule
